// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port SRAM macro.
// The slave modport is the arbiter's view. The master modport is the view of the requesters and the macro.
interface sram_port_arbiter_if #(
  parameter int AW = 10
);
  logic [1:0]    req_i;
  logic [1:0]    we_i;
  logic [AW-1:0] addr0_i;
  logic [AW-1:0] addr1_i;
  logic [31:0]   wdata0_i;
  logic [31:0]   wdata1_i;
  logic [3:0]    wmask0_i;
  logic [3:0]    wmask1_i;
  logic [1:0]    gnt_o;
  logic [1:0]    rvalid_o;
  logic [31:0]   rdata_o;
  logic          csb_o;
  logic          web_o;
  logic [AW-1:0] addr_o;
  logic [31:0]   wdata_o;
  logic [3:0]    wmask_o;
  logic [31:0]   rdata_i;

  modport slave (
    input  req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, wmask0_i, wmask1_i, rdata_i,
    output gnt_o, rvalid_o, rdata_o, csb_o, web_o, addr_o, wdata_o, wmask_o
  );

  modport master (
    output req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, wmask0_i, wmask1_i, rdata_i,
    input  gnt_o, rvalid_o, rdata_o, csb_o, web_o, addr_o, wdata_o, wmask_o
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter with a burst cap in front of a single-port 32-bit SRAM, with 1-cycle read-response routing.
// The optional program-loader lock is enabled by defining SRAM_ARB_PROG_LOCK_EN.
module sram_port_arbiter #(
  parameter int AW       = 10,
  parameter int MaxBurst = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
`ifdef SRAM_ARB_PROG_LOCK_EN
  input  logic                  prog_i,
`endif
  sram_port_arbiter_if.slave    bus
);

  localparam int CW = $clog2(MaxBurst + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MaxBurst);

  logic          r_last;
  logic [CW-1:0] r_cnt;
  logic          r_rd_vld;
  logic          r_rd_port;

  logic [1:0]    w_gnt;
  logic          w_acc;
  logic          w_port;
  logic          w_tie_port;
  logic          w_lock;

`ifdef SRAM_ARB_PROG_LOCK_EN
  assign w_lock = prog_i;
`else
  assign w_lock = 1'b0;
`endif

  // On a tie, a count of 0 means the owner idled last cycle, so the other port wins.
  always_comb begin
    w_tie_port = ~r_last;
    if ((r_cnt != '0) && (r_cnt < MAX_C)) begin
      w_tie_port = r_last;
    end
  end

  always_comb begin
    w_gnt = 2'b00;
    if (rst_ni) begin
      if (w_lock) begin
        w_gnt = {1'b0, bus.req_i[0]};
      end else begin
        unique case (bus.req_i)
          2'b01:   w_gnt = 2'b01;
          2'b10:   w_gnt = 2'b10;
          2'b11:   w_gnt = w_tie_port ? 2'b10 : 2'b01;
          default: w_gnt = 2'b00;
        endcase
      end
    end
  end

  assign w_acc  = |w_gnt;
  assign w_port = w_gnt[1];

  always_comb begin
    bus.gnt_o   = w_gnt;
    bus.csb_o   = ~w_acc;
    bus.web_o   = 1'b1;
    bus.addr_o  = '0;
    bus.wdata_o = '0;
    bus.wmask_o = '0;
    if (w_gnt[0]) begin
      bus.web_o   = ~bus.we_i[0];
      bus.addr_o  = bus.addr0_i;
      bus.wdata_o = bus.wdata0_i;
      bus.wmask_o = bus.wmask0_i;
    end else if (w_gnt[1]) begin
      bus.web_o   = ~bus.we_i[1];
      bus.addr_o  = bus.addr1_i;
      bus.wdata_o = bus.wdata1_i;
      bus.wmask_o = bus.wmask1_i;
    end
  end

  // Locking parks the arbiter at last=0, count=0, so port 1 wins the first tie after release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last <= 1'b1;
      r_cnt  <= '0;
    end else if (w_lock) begin
      r_last <= 1'b0;
      r_cnt  <= '0;
    end else if (w_acc) begin
      r_last <= w_port;
      if (w_port == r_last) begin
        r_cnt <= (r_cnt == MAX_C) ? MAX_C : r_cnt + 1'b1;
      end else begin
        r_cnt <= CW'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_vld  <= 1'b0;
      r_rd_port <= 1'b0;
    end else begin
      r_rd_vld  <= w_acc & ~bus.we_i[w_port];
      r_rd_port <= w_port;
    end
  end

  assign bus.rvalid_o = r_rd_vld ? (r_rd_port ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rdata_o  = bus.rdata_i;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter. Inputs change on the falling edge and outputs are sampled 1 ns later.
module tb_sram_port_arbiter;
  localparam int AW = 10;

  logic clk_i;
  logic rst_ni;
`ifdef SRAM_ARB_PROG_LOCK_EN
  logic prog_i;
`endif
  int total;
  int bad;

  sram_port_arbiter_if #(.AW(AW)) bus ();

  sram_port_arbiter #(.AW(AW), .MaxBurst(4)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
`ifdef SRAM_ARB_PROG_LOCK_EN
    .prog_i (prog_i),
`endif
    .bus    (bus.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, observed=running required=done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  initial begin
    int exp_port [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    total = 0;
    bad   = 0;
    rst_ni = 1'b0;
`ifdef SRAM_ARB_PROG_LOCK_EN
    prog_i = 1'b0;
`endif
    bus.req_i    = 2'b11;
    bus.we_i     = 2'b00;
    bus.addr0_i  = 10'h011;
    bus.addr1_i  = 10'h022;
    bus.wdata0_i = 32'h0;
    bus.wdata1_i = 32'h0;
    bus.wmask0_i = 4'h0;
    bus.wmask1_i = 4'h0;
    bus.rdata_i  = 32'h0;

    // Reset with both ports requesting.
    step(); step(); #1;
    chk("rst_gnt", bus.gnt_o, 2'b00);
    chk("rst_csb", bus.csb_o, 1'b1);
    chk("rst_web", bus.web_o, 1'b1);
    chk("rst_rvalid", bus.rvalid_o, 2'b00);
    chk("rst_addr", bus.addr_o, 10'h000);

    // Release and hold a tie for 10 cycles: burst-capped round robin.
    step();
    rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      #1;
      chk($sformatf("tie_gnt[%0d]", i), bus.gnt_o, (exp_port[i] == 1) ? 2'b10 : 2'b01);
      chk($sformatf("tie_addr[%0d]", i), bus.addr_o, (exp_port[i] == 1) ? 10'h022 : 10'h011);
      if (i > 0)
        chk($sformatf("tie_rvalid[%0d]", i), bus.rvalid_o, (exp_port[i-1] == 1) ? 2'b10 : 2'b01);
    end
    step();
    bus.req_i   = 2'b00;
    bus.rdata_i = 32'hCAFE0000;
    #1;
    chk("idle_gnt", bus.gnt_o, 2'b00);
    chk("idle_csb", bus.csb_o, 1'b1);
    chk("tail_rvalid", bus.rvalid_o, 2'b01);
    chk("tail_rdata", bus.rdata_o, 32'hCAFE0000);

    // Single read from port 1 at the top address.
    step();
    bus.req_i = 2'b10; bus.we_i = 2'b00; bus.addr1_i = 10'h3FF;
    #1;
    chk("rd1_gnt", bus.gnt_o, 2'b10);
    chk("rd1_csb", bus.csb_o, 1'b0);
    chk("rd1_web", bus.web_o, 1'b1);
    chk("rd1_addr", bus.addr_o, 10'h3FF);
    chk("rd1_rvalid_T", bus.rvalid_o, 2'b00);
    step();
    bus.req_i = 2'b00; bus.rdata_i = 32'hDEADBEEF;
    #1;
    chk("rd1_rvalid", bus.rvalid_o, 2'b10);
    chk("rd1_rdata", bus.rdata_o, 32'hDEADBEEF);
    step(); #1;
    chk("rd1_rvalid_once", bus.rvalid_o, 2'b00);

    // Port 0 write with a partial mask, then a zero-mask write.
    step();
    bus.req_i = 2'b01; bus.we_i = 2'b01; bus.addr0_i = 10'h155;
    bus.wmask0_i = 4'b0101; bus.wdata0_i = 32'h12345678;
    bus.wdata1_i = 32'hFFFFFFFF; bus.wmask1_i = 4'hF;
    #1;
    chk("wr_gnt", bus.gnt_o, 2'b01);
    chk("wr_csb", bus.csb_o, 1'b0);
    chk("wr_web", bus.web_o, 1'b0);
    chk("wr_wmask", bus.wmask_o, 4'b0101);
    chk("wr_wdata", bus.wdata_o, 32'h12345678);
    chk("wr_addr", bus.addr_o, 10'h155);
    step();
    bus.wmask0_i = 4'b0000;
    #1;
    chk("wr_no_rvalid", bus.rvalid_o, 2'b00);
    chk("wr0_csb", bus.csb_o, 1'b0);
    chk("wr0_web", bus.web_o, 1'b0);
    chk("wr0_wmask", bus.wmask_o, 4'b0000);
    step();
    bus.req_i = 2'b00; bus.we_i = 2'b00;
    #1;
    chk("wr0_no_rvalid", bus.rvalid_o, 2'b00);

    // Back-to-back reads: port 0 then port 1.
    step();
    bus.req_i = 2'b01; bus.addr0_i = 10'h010;
    #1;
    chk("b2b_gnt0", bus.gnt_o, 2'b01);
    step();
    bus.req_i = 2'b10; bus.addr1_i = 10'h020; bus.rdata_i = 32'hAAAA0001;
    #1;
    chk("b2b_gnt1", bus.gnt_o, 2'b10);
    chk("b2b_addr1", bus.addr_o, 10'h020);
    chk("b2b_rvalid0", bus.rvalid_o, 2'b01);
    chk("b2b_rdata0", bus.rdata_o, 32'hAAAA0001);
    step();
    bus.req_i = 2'b00; bus.rdata_i = 32'hBBBB0002;
    #1;
    chk("b2b_rvalid1", bus.rvalid_o, 2'b10);
    chk("b2b_rdata1", bus.rdata_o, 32'hBBBB0002);

    // Owner (port 1) idled last cycle, so port 0 wins the tie.
    step();
    bus.req_i = 2'b11;
    #1;
    chk("idle_tie_gnt", bus.gnt_o, 2'b01);
    // Port 1 alone for two cycles, then a tie stays with port 1.
    step();
    bus.req_i = 2'b10;
    #1;
    chk("solo1_gnt_a", bus.gnt_o, 2'b10);
    step(); #1;
    chk("solo1_gnt_b", bus.gnt_o, 2'b10);
    step();
    bus.req_i = 2'b11;
    #1;
    chk("keep_owner_gnt", bus.gnt_o, 2'b10);

    // Reset asserted while a read response is pending.
    step();
    bus.req_i = 2'b01; bus.we_i = 2'b00;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    bus.req_i = 2'b00;
    step(); #1;
    chk("rst_mid_rvalid", bus.rvalid_o, 2'b00);
    step();
    rst_ni = 1'b1;
    bus.req_i = 2'b11;
    #1;
    chk("post_rst_tie", bus.gnt_o, 2'b01);

`ifdef SRAM_ARB_PROG_LOCK_EN
    // Program lock: port 0 always wins, then port 1 wins the first tie after release.
    step();
    bus.req_i = 2'b00;
    step();
    prog_i = 1'b1;
    bus.req_i = 2'b11;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      #1;
      chk($sformatf("lock_gnt[%0d]", i), bus.gnt_o, 2'b01);
    end
    step();
    prog_i = 1'b0;
    #1;
    chk("unlock_tie_gnt", bus.gnt_o, 2'b10);
`endif

    step();
    bus.req_i = 2'b00;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
